// File: rtl/wb_port_sched.sv
// wb_port_sched: arbitrates a single register-file write port between the
// in-order pipeline WB stage and a multi-cycle unit. Multi-cycle results
// that cannot be written at once wait in a 2-entry FIFO; a starvation
// counter periodically forces the FIFO head ahead of the pipeline.
module wb_port_sched #(
   parameter int STARVE_LIMIT = 3,
   parameter int FIFO_DEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_we,
   input  logic [3:0]  pipe_addr,
   input  logic [15:0] pipe_data,
   output logic        pipe_stall,
   input  logic        mc_valid,
   input  logic [3:0]  mc_addr,
   input  logic [15:0] mc_data,
   output logic        mc_ready,
   output logic        rf_we,
   output logic [3:0]  rf_addr,
   output logic [15:0] rf_data,
   output logic [1:0]  fifo_cnt
);

   localparam logic [1:0] LIMIT    = 2'(STARVE_LIMIT);
   localparam logic [1:0] FULL_CNT = 2'(FIFO_DEPTH);

   typedef enum logic {ST_NORMAL, ST_FORCE} state_t;

   state_t      state, state_next;
   logic [1:0]  cnt;
   logic [1:0]  starve, starve_next;
   logic [19:0] ent0, ent1;        // {addr, data}; ent0 is the FIFO head
   logic        fifo_empty;
   logic        grant_pipe, grant_fifo, grant_bypass;
   logic        enq, deq;

   assign fifo_empty = (cnt == 2'd0);
   assign fifo_cnt   = cnt;
   assign deq        = grant_fifo;
   // Bypass consumes the result directly, so it never also enters the FIFO.
   assign enq        = !rst && mc_valid && mc_ready && !grant_bypass;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_NORMAL;
      else     state <= state_next;
   end

   // Next state: force the FIFO once the pipeline has starved it long enough;
   // FORCE lasts exactly one cycle.
   always_comb begin
      state_next = state;
      case (state)
         ST_NORMAL: if (grant_pipe && starve_next == LIMIT) state_next = ST_FORCE;
         ST_FORCE:  state_next = ST_NORMAL;
         default:   state_next = ST_NORMAL;
      endcase
   end

   // Grant selection and handshake outputs; everything idles during reset.
   always_comb begin
      grant_pipe   = 1'b0;
      grant_fifo   = 1'b0;
      grant_bypass = 1'b0;
      pipe_stall   = 1'b0;
      mc_ready     = 1'b1;
      if (!rst) begin
         mc_ready = (cnt != FULL_CNT);
         if (state == ST_FORCE && !fifo_empty) begin
            grant_fifo = 1'b1;
            pipe_stall = pipe_we;
         end else if (pipe_we) begin
            grant_pipe = 1'b1;
         end else if (!fifo_empty) begin
            grant_fifo = 1'b1;
         end else if (mc_valid) begin
            grant_bypass = 1'b1;
         end
      end
   end

   // Starve counter next value: counts pipeline wins over a waiting FIFO.
   always_comb begin
      starve_next = starve;
      if (deq || fifo_empty) starve_next = 2'd0;
      else if (grant_pipe)   starve_next = starve + 2'd1;
   end

   // Starve counter register.
   always_ff @(posedge clk) begin
      if (rst) starve <= 2'd0;
      else     starve <= starve_next;
   end

   // FIFO occupancy; enqueue is already blocked while full.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 2'd0;
      end else begin
         case ({enq, deq})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   // FIFO storage: shift on dequeue, write new entry into the first free slot.
   always_ff @(posedge clk) begin
      if (deq) ent0 <= ent1;
      if (enq) begin
         if (cnt == 2'd0 || (cnt == 2'd1 && deq)) ent0 <= {mc_addr, mc_data};
         else                                     ent1 <= {mc_addr, mc_data};
      end
   end

   // Register-file write port: one registered write per granted cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we   <= 1'b0;
         rf_addr <= 4'd0;
         rf_data <= 16'd0;
      end else begin
         rf_we <= grant_pipe | grant_fifo | grant_bypass;
         if (grant_pipe) begin
            rf_addr <= pipe_addr;
            rf_data <= pipe_data;
         end else if (grant_fifo) begin
            rf_addr <= ent0[19:16];
            rf_data <= ent0[15:0];
         end else if (grant_bypass) begin
            rf_addr <= mc_addr;
            rf_data <= mc_data;
         end
      end
   end

endmodule

// File: tb/tb_wb_port_sched.sv
// Directed testbench for wb_port_sched: one task per scenario, expected
// values computed by hand from the port arbitration rules.
module tb_wb_port_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_we;
   logic [3:0]  pipe_addr;
   logic [15:0] pipe_data;
   logic        pipe_stall;
   logic        mc_valid;
   logic [3:0]  mc_addr;
   logic [15:0] mc_data;
   logic        mc_ready;
   logic        rf_we;
   logic [3:0]  rf_addr;
   logic [15:0] rf_data;
   logic [1:0]  fifo_cnt;

   int total  = 0;
   int passed = 0;

   wb_port_sched #(.STARVE_LIMIT(3), .FIFO_DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
      .pipe_stall(pipe_stall),
      .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_data(mc_data),
      .mc_ready(mc_ready),
      .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
      .fifo_cnt(fifo_cnt)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Apply one cycle of inputs and let combinational outputs settle.
   task automatic drive(input logic pw, input logic [3:0] pa, input logic [15:0] pd,
                        input logic mv, input logic [3:0] ma, input logic [15:0] md);
      pipe_we = pw; pipe_addr = pa; pipe_data = pd;
      mc_valid = mv; mc_addr = ma; mc_data = md;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, 4'd4, 16'h4444, 1'b1, 4'd5, 16'h5555);
      total++; if (pipe_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", pipe_stall); else passed++;
      total++; if (mc_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", mc_ready); else passed++;
      tick(); tick();
      total++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we: got %b want 0", rf_we); else passed++;
      total++; if (rf_addr !== 4'd0) $display("FAIL reset_rf_addr: got %0h want 0", rf_addr); else passed++;
      total++; if (rf_data !== 16'h0) $display("FAIL reset_rf_data: got %0h want 0", rf_data); else passed++;
      total++; if (fifo_cnt !== 2'd0) $display("FAIL reset_cnt: got %0d want 0", fifo_cnt); else passed++;
      rst = 1'b0;
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      tick();
      total++; if (rf_we !== 1'b0) $display("FAIL reset_idle_we: got %b want 0", rf_we); else passed++;
   endtask

   task automatic test_bypass();
      drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 16'h1234);
      total++; if (mc_ready !== 1'b1) $display("FAIL bypass_ready: got %b want 1", mc_ready); else passed++;
      tick();
      total++; if (rf_we !== 1'b1) $display("FAIL bypass_we: got %b want 1", rf_we); else passed++;
      total++; if (rf_addr !== 4'd5) $display("FAIL bypass_addr: got %0h want 5", rf_addr); else passed++;
      total++; if (rf_data !== 16'h1234) $display("FAIL bypass_data: got %0h want 1234", rf_data); else passed++;
      total++; if (fifo_cnt !== 2'd0) $display("FAIL bypass_cnt: got %0d want 0", fifo_cnt); else passed++;
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      tick();
      total++; if (rf_we !== 1'b0) $display("FAIL idle_we: got %b want 0", rf_we); else passed++;
      total++; if (rf_data !== 16'h1234) $display("FAIL idle_hold_data: got %0h want 1234", rf_data); else passed++;
      total++; if (rf_addr !== 4'd5) $display("FAIL idle_hold_addr: got %0h want 5", rf_addr); else passed++;
   endtask

   task automatic test_conflict();
      drive(1'b1, 4'd2, 16'hAAAA, 1'b1, 4'd3, 16'hBBBB);
      total++; if (pipe_stall !== 1'b0) $display("FAIL conflict_stall: got %b want 0", pipe_stall); else passed++;
      tick();
      total++; if (rf_addr !== 4'd2 || rf_data !== 16'hAAAA || rf_we !== 1'b1)
         $display("FAIL conflict_pipe: got we=%b %0h/%0h want 1 2/aaaa", rf_we, rf_addr, rf_data); else passed++;
      total++; if (fifo_cnt !== 2'd1) $display("FAIL conflict_cnt: got %0d want 1", fifo_cnt); else passed++;
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      tick();
      total++; if (rf_addr !== 4'd3 || rf_data !== 16'hBBBB || rf_we !== 1'b1)
         $display("FAIL conflict_drain: got we=%b %0h/%0h want 1 3/bbbb", rf_we, rf_addr, rf_data); else passed++;
      total++; if (fifo_cnt !== 2'd0) $display("FAIL conflict_drain_cnt: got %0d want 0", fifo_cnt); else passed++;
   endtask

   task automatic test_full();
      drive(1'b1, 4'd1, 16'h1111, 1'b1, 4'd6, 16'h6666);
      tick();
      drive(1'b1, 4'd1, 16'h1112, 1'b1, 4'd7, 16'h7777);
      tick();
      total++; if (fifo_cnt !== 2'd2) $display("FAIL full_cnt: got %0d want 2", fifo_cnt); else passed++;
      drive(1'b1, 4'd1, 16'h1113, 1'b1, 4'd8, 16'h8888);
      total++; if (mc_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", mc_ready); else passed++;
      total++; if (pipe_stall !== 1'b0) $display("FAIL full_stall: got %b want 0", pipe_stall); else passed++;
      tick();
      total++; if (fifo_cnt !== 2'd2) $display("FAIL full_no_enq: got %0d want 2", fifo_cnt); else passed++;
      total++; if (rf_data !== 16'h1113) $display("FAIL full_pipe_data: got %0h want 1113", rf_data); else passed++;
      // Third pipeline win over a waiting FIFO triggers the forced slot.
      drive(1'b1, 4'd1, 16'h1114, 1'b0, 4'd0, 16'h0);
      tick();
      total++; if (pipe_stall !== 1'b1) $display("FAIL full_force_stall: got %b want 1", pipe_stall); else passed++;
      tick();
      total++; if (rf_addr !== 4'd6 || rf_data !== 16'h6666) $display("FAIL full_force_head: got %0h/%0h want 6/6666", rf_addr, rf_data); else passed++;
      total++; if (fifo_cnt !== 2'd1) $display("FAIL full_force_cnt: got %0d want 1", fifo_cnt); else passed++;
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      tick();
      total++; if (rf_addr !== 4'd7 || rf_data !== 16'h7777) $display("FAIL full_second: got %0h/%0h want 7/7777", rf_addr, rf_data); else passed++;
      total++; if (fifo_cnt !== 2'd0) $display("FAIL full_empty: got %0d want 0", fifo_cnt); else passed++;
      tick();
      total++; if (rf_we !== 1'b0) $display("FAIL full_rejected_written: got %b want 0", rf_we); else passed++;
   endtask

   task automatic test_starvation();
      drive(1'b1, 4'd2, 16'h0202, 1'b1, 4'd9, 16'h9999);
      tick();
      total++; if (fifo_cnt !== 2'd1) $display("FAIL starve_load: got %0d want 1", fifo_cnt); else passed++;
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 4'd2, 16'(i), 1'b0, 4'd0, 16'h0);
         total++; if (pipe_stall !== 1'b0) $display("FAIL starve_grant%0d_stall: got %b want 0", i, pipe_stall); else passed++;
         tick();
         total++; if (rf_data !== 16'(i) || rf_we !== 1'b1) $display("FAIL starve_grant%0d: got we=%b %0h want 1 %0h", i, rf_we, rf_data, i); else passed++;
      end
      drive(1'b1, 4'd2, 16'h0004, 1'b0, 4'd0, 16'h0);
      total++; if (pipe_stall !== 1'b1) $display("FAIL starve_force_stall: got %b want 1", pipe_stall); else passed++;
      tick();
      total++; if (rf_addr !== 4'd9 || rf_data !== 16'h9999) $display("FAIL starve_force_write: got %0h/%0h want 9/9999", rf_addr, rf_data); else passed++;
      total++; if (fifo_cnt !== 2'd0) $display("FAIL starve_force_cnt: got %0d want 0", fifo_cnt); else passed++;
      total++; if (pipe_stall !== 1'b0) $display("FAIL starve_resume_stall: got %b want 0", pipe_stall); else passed++;
      tick();
      total++; if (rf_addr !== 4'd2 || rf_data !== 16'h0004) $display("FAIL starve_resume: got %0h/%0h want 2/0004", rf_addr, rf_data); else passed++;
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      tick();
   endtask

   task automatic test_simultaneous();
      drive(1'b1, 4'd1, 16'h0101, 1'b1, 4'hA, 16'hA0A0);
      tick();
      drive(1'b0, 4'd0, 16'h0, 1'b1, 4'hB, 16'hB0B0);
      tick();
      total++; if (rf_addr !== 4'hA || rf_data !== 16'hA0A0) $display("FAIL simul_deq: got %0h/%0h want a/a0a0", rf_addr, rf_data); else passed++;
      total++; if (fifo_cnt !== 2'd1) $display("FAIL simul_cnt: got %0d want 1", fifo_cnt); else passed++;
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      tick();
      total++; if (rf_addr !== 4'hB || rf_data !== 16'hB0B0) $display("FAIL simul_order: got %0h/%0h want b/b0b0", rf_addr, rf_data); else passed++;
      total++; if (fifo_cnt !== 2'd0) $display("FAIL simul_empty: got %0d want 0", fifo_cnt); else passed++;
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 4'd1, 16'hC101, 1'b1, 4'd1, 16'hC001);
      tick();
      drive(1'b1, 4'd1, 16'hC102, 1'b1, 4'd2, 16'hC002);
      tick();
      drive(1'b1, 4'd1, 16'hC103, 1'b0, 4'd0, 16'h0);
      tick();
      tick();
      total++; if (pipe_stall !== 1'b1 || fifo_cnt !== 2'd2) $display("FAIL mid_setup: got stall=%b cnt=%0d want 1 2", pipe_stall, fifo_cnt); else passed++;
      rst = 1'b1;
      drive(1'b1, 4'd1, 16'hC104, 1'b1, 4'd3, 16'hC003);
      total++; if (pipe_stall !== 1'b0 || mc_ready !== 1'b1) $display("FAIL mid_rst_comb: got stall=%b ready=%b want 0 1", pipe_stall, mc_ready); else passed++;
      tick();
      total++; if (rf_we !== 1'b0) $display("FAIL mid_rst_we: got %b want 0", rf_we); else passed++;
      total++; if (fifo_cnt !== 2'd0) $display("FAIL mid_rst_cnt: got %0d want 0", fifo_cnt); else passed++;
      rst = 1'b0;
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      total++; if (mc_ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", mc_ready); else passed++;
      tick();
      total++; if (rf_we !== 1'b0) $display("FAIL mid_no_stale_write: got %b want 0", rf_we); else passed++;
      drive(1'b1, 4'd7, 16'hD00D, 1'b0, 4'd0, 16'h0);
      total++; if (pipe_stall !== 1'b0) $display("FAIL mid_normal: got %b want 0", pipe_stall); else passed++;
      tick();
      total++; if (rf_addr !== 4'd7 || rf_data !== 16'hD00D) $display("FAIL mid_pipe: got %0h/%0h want 7/d00d", rf_addr, rf_data); else passed++;
   endtask

   initial begin
      rst = 1'b1;
      pipe_we = 1'b0; pipe_addr = 4'd0; pipe_data = 16'h0;
      mc_valid = 1'b0; mc_addr = 4'd0; mc_data = 16'h0;
      @(negedge clk);
      test_reset();
      test_bypass();
      test_conflict();
      test_full();
      test_starvation();
      test_simultaneous();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
